// File: rtl/rl_fifo_pkg.sv
// rl_fifo_pkg: sizing helpers shared by the RAM-backed FIFO and its output buffer
package rl_fifo_pkg;
    localparam int OBUF_DEPTH = 2;
    localparam int CNT_EXTRA  = 2;

    // Total capacity: the RAM plus the output buffer entries.
    function automatic int fifo_cap(input int abits);
        return (1 << abits) + OBUF_DEPTH;
    endfunction

    function automatic int cnt_bits(input int abits);
        return abits + CNT_EXTRA;
    endfunction
endpackage

// File: rtl/rl_fifo_obuf.sv
// rl_fifo_obuf: 2-entry register FIFO that turns RAM read data into a registered FWFT pop port
module rl_fifo_obuf #(
    parameter int DBITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [DBITS-1:0] load_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [DBITS-1:0] data_o,
    output logic [1:0]       cnt_o
);
    logic [DBITS-1:0] head_q, tail_q, head_d, tail_d;
    logic [1:0]       cnt_q, cnt_d, slot;
    logic             pop;

    assign valid_o = cnt_q != 2'd0;
    assign pop     = valid_o & ready_i;
    assign data_o  = head_q;
    assign cnt_o   = cnt_q;

    // A load lands in the first slot left free after this cycle's pop.
    always_comb begin
        slot   = cnt_q - {1'b0, pop};
        head_d = (load_i && slot == 2'd0) ? load_data_i : pop ? tail_q : head_q;
        tail_d = (load_i && slot == 2'd1) ? load_data_i : tail_q;
        cnt_d  = flush_i ? 2'd0 : slot + {1'b0, load_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/rl_ram_1r1w.sv
// rl_ram_1r1w: 1-read 1-write RAM wrapper, byte-enabled write, registered read data
module rl_ram_1r1w #(
    parameter int    ABITS         = 4,
    parameter int    DBITS         = 32,
    parameter string TECHNOLOGY    = "GENERIC",
    parameter string RW_CONTENTION = "DONT_CARE"
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [ABITS-1:0]   waddr_i,
    input  logic [DBITS/8-1:0] be_i,
    input  logic [DBITS-1:0]   din_i,
    input  logic               re_i,
    input  logic [ABITS-1:0]   raddr_i,
    output logic [DBITS-1:0]   dout_o
);
    // Only the generic model forwards same-address write data; otherwise old data is read.
    localparam bit WRITE_FIRST = (TECHNOLOGY == "GENERIC") && (RW_CONTENTION == "WRITE_FIRST");

    logic [DBITS-1:0] mem [2**ABITS];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DBITS/8; b++)
            if (we_i && be_i[b]) mem[waddr_i][b*8 +: 8] <= din_i[b*8 +: 8];
        if (re_i) dout_o <= (WRITE_FIRST && we_i && waddr_i == raddr_i) ? din_i : mem[raddr_i];
    end
endmodule

// File: rtl/rl_ram_fifo.sv
// rl_ram_fifo: FIFO over rl_ram_1r1w with a 2-entry output buffer hiding the RAM read latency
module rl_ram_fifo import rl_fifo_pkg::*; #(
    parameter int    ABITS      = 4,
    parameter int    DBITS      = 32,
    parameter int    AFULL_LVL  = 2**ABITS,
    parameter string TECHNOLOGY = "GENERIC"
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [DBITS-1:0]   s_data_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [DBITS-1:0]   m_data_o,
    output logic [ABITS+1:0]   count_o,
    output logic               empty_o,
    output logic               full_o,
    output logic               almost_full_o
);
    localparam int            CW    = cnt_bits(ABITS);
    localparam logic [CW-1:0] CAP   = CW'(fifo_cap(ABITS));
    localparam logic [CW-1:0] AFULL = CW'(AFULL_LVL);

    logic [ABITS:0]   wptr_q, rptr_q, ram_cnt;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       obuf_cnt;
    logic [2:0]       obuf_need;
    logic [DBITS-1:0] ram_dout;
    logic             rd_pending_q, s_ready_q, push, pop, rd_issue;

    assign push      = s_valid_i & s_ready_q & ~flush_i;
    assign pop       = m_valid_o & m_ready_i;
    assign ram_cnt   = wptr_q - rptr_q;
    // Read only while the buffer, counting the in-flight read and this cycle's pop, has room.
    assign obuf_need = {1'b0, obuf_cnt} + {2'b0, rd_pending_q} - {2'b0, pop};
    assign rd_issue  = !flush_i && ram_cnt != '0 && obuf_need < 3'd2;
    assign count_d   = flush_i ? '0 : count_q + CW'(push) - CW'(pop);

    assign s_ready_o     = s_ready_q;
    assign count_o       = count_q;
    assign empty_o       = count_q == '0;
    assign full_o        = count_q == CAP;
    assign almost_full_o = count_q >= AFULL;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            rd_pending_q <= 1'b0;
            s_ready_q    <= 1'b1;
        end else begin
            wptr_q       <= flush_i ? '0 : wptr_q + {{ABITS{1'b0}}, push};
            rptr_q       <= flush_i ? '0 : rptr_q + {{ABITS{1'b0}}, rd_issue};
            count_q      <= count_d;
            rd_pending_q <= rd_issue;
            s_ready_q    <= count_d != CAP;
        end
    end

    rl_ram_1r1w #(
        .ABITS         (ABITS),
        .DBITS         (DBITS),
        .TECHNOLOGY    (TECHNOLOGY),
        .RW_CONTENTION ("DONT_CARE")
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wptr_q[ABITS-1:0]),
        .be_i    ('1),
        .din_i   (s_data_i),
        .re_i    (rd_issue),
        .raddr_i (rptr_q[ABITS-1:0]),
        .dout_o  (ram_dout)
    );

    rl_fifo_obuf #(
        .DBITS (DBITS)
    ) u_obuf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .load_i      (rd_pending_q & ~flush_i),
        .load_data_i (ram_dout),
        .ready_i     (m_ready_i),
        .valid_o     (m_valid_o),
        .data_o      (m_data_o),
        .cnt_o       (obuf_cnt)
    );
endmodule
